// File: rtl/pll_reset_sequencer_if.sv
// Status/control bundle between the PLL reset sequencer and the rest of the design.
// The slave side is the sequencer; the master side drives lock and relock requests.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic       fail;
  logic       lost_lock;
  logic [7:0] retry_count;

  modport master (
    output pll_locked,
    output force_relock,
    input  pll_rst,
    input  core_rst,
    input  ready,
    input  fail,
    input  lost_lock,
    input  retry_count
  );

  modport slave (
    input  pll_locked,
    input  force_relock,
    output pll_rst,
    output core_rst,
    output ready,
    output fail,
    output lost_lock,
    output retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock controller on the reference clock: pulses PLL reset, waits for lock with
// timeout and retry, qualifies lock stability, then releases the core reset.
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 500,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned CNT_W               = 20
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.slave  bus
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

  logic [1:0]       sync_q, sync_d;
  logic             lk_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_count_q, retry_count_d;
  logic             pll_rst_q, pll_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             lost_lock_q, lost_lock_d;

  // Two-flop synchroniser for the asynchronous lock flag; only the second stage is used.
  assign sync_d = {sync_q[0], bus.pll_locked};
  assign lk_s   = sync_q[1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_count_d = retry_count_q;
    lost_lock_d   = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (lk_s) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d         = '0;
          retry_count_d = (retry_count_q == 8'hFF) ? 8'hFF : retry_count_q + 8'd1;
          if ((MAX_RETRIES != 0) && (retry_count_d == RETRY_LIMIT)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RESET;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lk_s) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          lost_lock_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_RESET;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_RESET;
      end
    endcase

    // A relock request overrides the transition but leaves a coincident lost_lock pulse intact.
    if (bus.force_relock) begin
      state_d       = ST_RESET;
      cnt_d         = '0;
      retry_count_d = 8'd0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_rst_d  = (state_d == ST_RESET) || (state_d == ST_FAIL);
    core_rst_d = (state_d != ST_RUN);
    ready_d    = (state_d == ST_RUN);
    fail_d     = (state_d == ST_FAIL);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q        <= 2'b00;
      state_q       <= ST_RESET;
      cnt_q         <= '0;
      retry_count_q <= 8'd0;
      pll_rst_q     <= 1'b1;
      core_rst_q    <= 1'b1;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
      lost_lock_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_count_q <= retry_count_d;
      pll_rst_q     <= pll_rst_d;
      core_rst_q    <= core_rst_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
      lost_lock_q   <= lost_lock_d;
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.core_rst    = core_rst_q;
  assign bus.ready       = ready_q;
  assign bus.fail        = fail_q;
  assign bus.lost_lock   = lost_lock_q;
  assign bus.retry_count = retry_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed vector bench for pll_reset_sequencer with small timing parameters
// (hold 4, timeout 20, stable 8, two retries).
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  typedef struct {
    logic       rst;
    logic       lk;
    logic       frc;
    int         n;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic       fail;
    logic       lost_lock;
    logic [7:0] rc;
  } vec_t;

  logic refclk = 1'b0;
  logic rst;
  int   n_applied = 0;
  int   n_miscompares = 0;
  vec_t vecs[$];

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .CNT_W               (8)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #10 refclk = ~refclk;

  function automatic void add(input logic r, input logic l, input logic f, input int n,
                              input logic pr, input logic cr, input logic rd,
                              input logic fl, input logic ll, input logic [7:0] rc);
    vec_t v;
    v.rst = r; v.lk = l; v.frc = f; v.n = n;
    v.pll_rst = pr; v.core_rst = cr; v.ready = rd; v.fail = fl; v.lost_lock = ll; v.rc = rc;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [12:0] got;
    logic [12:0] exp;
    int          hi_cycles;

    rst = 1'b1;
    bus.pll_locked   = 1'b0;
    bus.force_relock = 1'b0;

    // Power-up reset, hold pulse, lock asserted on WAIT entry
    add(1,0,0, 3, 1,1,0,0,0,0);
    add(0,0,0, 1, 1,1,0,0,0,0);
    add(0,0,0, 1, 1,1,0,0,0,0);
    add(0,0,0, 1, 1,1,0,0,0,0);
    add(0,0,0, 1, 0,1,0,0,0,0);
    add(0,1,0,10, 0,1,0,0,0,0);
    add(0,1,0, 1, 0,0,1,0,0,0);
    add(0,1,0, 5, 0,0,1,0,0,0);
    // Lock lost in RUN: pulse after sync latency, re-run hold and qualification
    add(0,0,0, 2, 0,0,1,0,0,0);
    add(0,0,0, 1, 1,1,0,0,1,0);
    add(0,0,0, 1, 1,1,0,0,0,0);
    add(0,0,0, 2, 1,1,0,0,0,0);
    add(0,0,0, 1, 0,1,0,0,0,0);
    add(0,1,0,10, 0,1,0,0,0,0);
    add(0,1,0, 1, 0,0,1,0,0,0);
    // Relock from RUN with lock held, then a 1-cycle lock glitch seen at STABLE count 5
    add(0,1,1, 1, 1,1,0,0,0,0);
    add(0,1,0, 3, 1,1,0,0,0,0);
    add(0,1,0, 1, 0,1,0,0,0,0);
    add(0,1,0, 4, 0,1,0,0,0,0);
    add(0,0,0, 1, 0,1,0,0,0,0);
    add(0,1,0,10, 0,1,0,0,0,0);
    add(0,1,0, 1, 0,0,1,0,0,0);
    // Reset during RUN, then two timeouts into FAIL, then relock request
    add(1,0,0, 1, 1,1,0,0,0,0);
    add(0,0,0, 3, 1,1,0,0,0,0);
    add(0,0,0, 1, 0,1,0,0,0,0);
    add(0,0,0,19, 0,1,0,0,0,0);
    add(0,0,0, 1, 1,1,0,0,0,1);
    add(0,0,0, 3, 1,1,0,0,0,1);
    add(0,0,0, 1, 0,1,0,0,0,1);
    add(0,0,0,19, 0,1,0,0,0,1);
    add(0,0,0, 1, 1,1,0,1,0,2);
    add(0,0,0,30, 1,1,0,1,0,2);
    add(0,0,1, 1, 1,1,0,0,0,0);
    add(0,0,0, 3, 1,1,0,0,0,0);
    add(0,0,0, 1, 0,1,0,0,0,0);
    // One timeout, then reset during WAIT clears the retry count
    add(0,0,0,20, 1,1,0,0,0,1);
    add(0,0,0, 4, 0,1,0,0,0,1);
    add(0,0,0, 5, 0,1,0,0,0,1);
    add(1,0,0, 1, 1,1,0,0,0,0);
    // Reach RUN with one retry, then relock coincident with lock loss
    add(0,0,0, 4, 0,1,0,0,0,0);
    add(0,0,0,20, 1,1,0,0,0,1);
    add(0,0,0, 4, 0,1,0,0,0,1);
    add(0,1,0,10, 0,1,0,0,0,1);
    add(0,1,0, 1, 0,0,1,0,0,1);
    add(0,0,0, 2, 0,0,1,0,0,1);
    add(0,0,1, 1, 1,1,0,0,1,0);
    add(0,0,0, 1, 1,1,0,0,0,0);
    add(0,0,0, 2, 1,1,0,0,0,0);
    add(0,0,0, 1, 0,1,0,0,0,0);

    foreach (vecs[i]) begin
      rst              = vecs[i].rst;
      bus.pll_locked   = vecs[i].lk;
      bus.force_relock = vecs[i].frc;
      repeat (vecs[i].n) @(posedge refclk);
      #1;
      got = {bus.pll_rst, bus.core_rst, bus.ready, bus.fail, bus.lost_lock, bus.retry_count};
      exp = {vecs[i].pll_rst, vecs[i].core_rst, vecs[i].ready, vecs[i].fail,
             vecs[i].lost_lock, vecs[i].rc};
      n_applied++;
      if (got !== exp) begin
        n_miscompares++;
        $display("FAIL vec%0d {pll_rst,core_rst,ready,fail,lost_lock,retry} got %b_%b_%b_%b_%b_%0d want %b_%b_%b_%b_%b_%0d",
                 i, got[12], got[11], got[10], got[9], got[8], got[7:0],
                 exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end else begin
        $display("vec%0d ok: pll_rst=%b core_rst=%b ready=%b fail=%b lost_lock=%b retry=%0d",
                 i, got[12], got[11], got[10], got[9], got[8], got[7:0]);
      end
    end

    // Measure the PLL reset pulse width cycle by cycle after a fresh reset
    rst = 1'b1;
    bus.pll_locked   = 1'b0;
    bus.force_relock = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    rst = 1'b0;
    hi_cycles = 0;
    for (int k = 0; k < 50 && bus.pll_rst === 1'b1; k++) begin
      hi_cycles++;
      @(posedge refclk);
      #1;
    end
    n_applied++;
    if (hi_cycles != 4) begin
      n_miscompares++;
      $display("FAIL pll_rst_width got %0d cycles want 4", hi_cycles);
    end else begin
      $display("pll_rst_width ok: %0d cycles", hi_cycles);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
